uart_cfg: RTL and testbench
===========================

Name: uart_cfg

Overview:
- Configurable UART transceiver; successor to the fixed 8N1 UART used by the wavetrace host link.
- Compile-time data width (5-9 bits), parity mode and stop-bit count.
- Per-byte receive status: framing error, parity error, overrun pulse.
- Sits between the host serial pins and the valid/ready byte streams of the capture and control logic.

Parameters:
- ClockHz, 80000000, system clock frequency in Hz.
- Baud, 115200, line rate. Period = ClockHz/Baud (integer division), must be >= 4. HalfPeriod = Period/2.
- DataBits, 8, data bits per frame, legal range 5..9, sent and received LSB first.
- Parity, 0, 0 = none, 1 = even, 2 = odd.
- StopBits, 1, stop bits per frame, 1 or 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- uart_rx  in  1  asynchronous serial input, idle high
- uart_tx  out  1  serial output, idle high, registered
- din_valid  in  1  transmit word valid
- din_ready  out  1  transmitter idle; a word is accepted when din_valid && din_ready
- din_data  in  DataBits  transmit word
- dout_valid  out  1  received word held
- dout_ready  in  1  consumer accepts the held word
- dout_data  out  DataBits  received word
- dout_frame_err  out  1  a stop bit of the held word sampled 0
- dout_parity_err  out  1  parity mismatch on the held word; always 0 when Parity=0
- rx_overrun  out  1  one-cycle pulse: a completed word was dropped

Behaviour:
- Reset values: uart_tx=1, din_ready=1, dout_valid=0, dout_frame_err=0, dout_parity_err=0, rx_overrun=0. Both state machines go to Idle.
- Reset mid-frame aborts immediately; uart_tx is 1 on the cycle after rst.
- Frame length: N = 1 + DataBits + (Parity!=0) + StopBits bits.
- Parity bit:
  - even: XOR of the data bits;
  - odd: inverted XOR of the data bits.
- TX state machine, Idle -> Start -> Data -> Parity (skipped when Parity=0) -> Stop -> Idle:
  - A word is accepted at cycle 0 and latched.
  - uart_tx drives each bit for exactly Period cycles, starting at cycle 1.
  - din_ready=0 from cycle 1 through cycle N*Period.
  - din_ready=1 at cycle N*Period+1, so back-to-back words produce no extra idle time.
  - din_data is ignored while din_ready=0.
- RX input sync: uart_rx passes through a 2-flop synchroniser (rx_sync), adding 2 cycles of latency.
- RX state machine, Idle -> Start -> Data -> Parity -> Stop -> Idle, plus an Error state:
  - Idle:
    - Count consecutive cycles with rx_sync=0.
    - If rx_sync returns to 1 before the count reaches HalfPeriod, clear the count and stay Idle (glitch rejection).
    - When the count reaches HalfPeriod, the point is mid start bit; go to Data.
  - Each following bit is sampled Period cycles after the previous sample point.
  - Data bits shift in LSB first. The parity bit is compared with the computed parity.
  - At each stop-bit sample:
    - stop bit 0: set frame_err and go to Error;
    - otherwise continue, returning to Idle after the last stop bit.
  - Error: wait for rx_sync=1, then go to Idle.
  - A word is completed at the last stop-bit sample, including framing-error words.
- Output buffer (single word):
  - On completion, when dout_valid=0 or dout_ready=1 in that cycle: dout_data and both error flags load on the next cycle, and dout_valid=1.
  - On completion with dout_valid=1 and dout_ready=0: the held word is kept unchanged, the new word is discarded, and rx_overrun=1 for one cycle.
  - dout_valid && dout_ready with no completion that cycle: dout_valid=0 on the next cycle.
  - Held data and flags stay stable while dout_valid=1 && dout_ready=0.
- Counters:
  - Bit timers are clog2(Period) bits wide and wrap to 0 at Period-1.
  - Bit counters are 4 bits wide.
- RX and TX are fully independent; simultaneous activity is legal, including loopback of uart_tx to uart_rx.

Decomposition:
- Package uart_pkg holds:
  - parity constants ParNone=0, ParEven=1, ParOdd=2;
  - RX/TX state encodings;
  - function frame_bits(DataBits, Parity, StopBits);
  - a clog2 helper.
- One sub-module, uart_cfg_rx: synchroniser, RX state machine and the one-word output buffer with status flags.
- TX stays in the top level.

Test Plan (ClockHz=1000000, Baud=100000, so Period=10):
- 8N1, send 0xA5 -> uart_tx reads 0,1,0,1,0,0,1,0,1,1, each level held 10 cycles; din_ready=0 for 100 cycles, then 1.
- 7E2 loopback of 0x35 -> dout_data=0x35, parity bit sent=0, frame_err=0, parity_err=0; din_ready low for 110 cycles.
- 8O1, drive a frame with the parity bit flipped -> dout_parity_err=1, correct dout_data, dout_valid=1.
- 8N1, drive a frame with stop=0 for 0x3C -> dout_valid=1, dout_data=0x3C, dout_frame_err=1; a following good frame after the line idles is received cleanly.
- Hold dout_ready=0 and receive 0x11 then 0x22 -> dout_data stays 0x11, one rx_overrun pulse; with dout_ready=1 on the second completion cycle, dout_data=0x22 and no pulse.
- Assert a 3-cycle low glitch on uart_rx -> no word; assert rst mid-TX -> uart_tx=1 and din_ready=1 on the next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity modes, state encodings
// and elaboration-time helpers.
package uart_pkg;

   localparam int ParNone = 0;
   localparam int ParEven = 1;
   localparam int ParOdd  = 2;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_ERROR
   } rx_state_t;

   function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
      return 1 + data_bits + ((parity != ParNone) ? 1 : 0) + stop_bits;
   endfunction

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_cfg_rx.sv
// UART receiver: input synchroniser, bit-timing FSM and a one-word output
// buffer carrying framing/parity status and an overrun pulse.
//
// state     | meaning
// RX_IDLE   | line idle; counts low cycles to find mid start bit
// RX_DATA   | sampling data bits, LSB first
// RX_PARITY | sampling and checking the parity bit
// RX_STOP   | sampling stop bit(s)
// RX_ERROR  | stop bit was 0; waiting for the line to return high
module uart_cfg_rx
   import uart_pkg::*;
#(
   parameter int Period   = 10,
   parameter int DataBits = 8,
   parameter int Parity   = 0,
   parameter int StopBits = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                uart_rx,
   output logic                dout_valid,
   input  logic                dout_ready,
   output logic [DataBits-1:0] dout_data,
   output logic                dout_frame_err,
   output logic                dout_parity_err,
   output logic                rx_overrun
);

   localparam int HalfPeriod = Period / 2;
   localparam int TW         = clog2(Period);

   logic                rx_meta;
   logic                rx_sync;
   rx_state_t           state;
   rx_state_t           state_nxt;
   logic [TW-1:0]       timer;
   logic [TW-1:0]       timer_nxt;
   logic [3:0]          bit_cnt;
   logic [3:0]          bit_cnt_nxt;
   logic [DataBits-1:0] shreg;
   logic [DataBits-1:0] shreg_nxt;
   logic                par_err;
   logic                par_err_nxt;
   logic                par_calc;
   logic                tick;
   logic                done;
   logic                done_ferr;

   assign tick     = (timer == TW'(Period - 1));
   assign par_calc = (Parity == ParOdd) ? ~(^shreg) : (^shreg);

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_sync <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RX_IDLE;
         timer   <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         bit_cnt <= bit_cnt_nxt;
         shreg   <= shreg_nxt;
         par_err <= par_err_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      timer_nxt   = tick ? '0 : timer + 1'b1;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      par_err_nxt = par_err;
      done        = 1'b0;
      done_ferr   = 1'b0;
      case (state)
         RX_IDLE: begin
            if (!rx_sync) begin
               if (timer == TW'(HalfPeriod - 1)) begin
                  state_nxt   = RX_DATA;
                  timer_nxt   = '0;
                  bit_cnt_nxt = '0;
                  par_err_nxt = 1'b0;
               end else begin
                  timer_nxt = timer + 1'b1;
               end
            end else begin
               timer_nxt = '0;
            end
         end
         RX_DATA: begin
            if (tick) begin
               shreg_nxt = {rx_sync, shreg[DataBits-1:1]};
               if (bit_cnt == 4'(DataBits - 1)) begin
                  bit_cnt_nxt = '0;
                  state_nxt   = (Parity != ParNone) ? RX_PARITY : RX_STOP;
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end
         end
         RX_PARITY: begin
            if (tick) begin
               par_err_nxt = (rx_sync != par_calc);
               state_nxt   = RX_STOP;
            end
         end
         RX_STOP: begin
            if (tick) begin
               // a failed stop bit ends the frame early but still delivers the word
               if (!rx_sync) begin
                  done      = 1'b1;
                  done_ferr = 1'b1;
                  state_nxt = RX_ERROR;
               end else if (bit_cnt == 4'(StopBits - 1)) begin
                  done      = 1'b1;
                  state_nxt = RX_IDLE;
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end
         end
         RX_ERROR: begin
            timer_nxt = '0;
            if (rx_sync) state_nxt = RX_IDLE;
         end
         default: begin
            state_nxt = RX_IDLE;
            timer_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_valid      <= 1'b0;
         dout_data       <= '0;
         dout_frame_err  <= 1'b0;
         dout_parity_err <= 1'b0;
         rx_overrun      <= 1'b0;
      end else begin
         rx_overrun <= 1'b0;
         if (done) begin
            if (!dout_valid || dout_ready) begin
               dout_valid      <= 1'b1;
               dout_data       <= shreg;
               dout_frame_err  <= done_ferr;
               dout_parity_err <= par_err;
            end else begin
               rx_overrun <= 1'b1;
            end
         end else if (dout_ready) begin
            dout_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/uart_cfg.sv
// Configurable UART transceiver top: transmitter FSM plus the receiver block.
//
// state     | meaning
// TX_IDLE   | waiting for a word, din_ready high
// TX_START  | driving the start bit
// TX_DATA   | driving data bits, LSB first
// TX_PARITY | driving the parity bit
// TX_STOP   | driving stop bit(s)
module uart_cfg
   import uart_pkg::*;
#(
   parameter int ClockHz  = 80000000,
   parameter int Baud     = 115200,
   parameter int DataBits = 8,
   parameter int Parity   = 0,
   parameter int StopBits = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                uart_rx,
   output logic                uart_tx,
   input  logic                din_valid,
   output logic                din_ready,
   input  logic [DataBits-1:0] din_data,
   output logic                dout_valid,
   input  logic                dout_ready,
   output logic [DataBits-1:0] dout_data,
   output logic                dout_frame_err,
   output logic                dout_parity_err,
   output logic                rx_overrun
);

   localparam int Period    = ClockHz / Baud;
   localparam int TW        = clog2(Period);
   localparam int FrameBits = frame_bits(DataBits, Parity, StopBits);

   tx_state_t           tx_state;
   tx_state_t           tx_state_nxt;
   logic [TW-1:0]       tx_timer;
   logic [TW-1:0]       tx_timer_nxt;
   logic [3:0]          tx_pos;
   logic [3:0]          tx_pos_nxt;
   logic [DataBits-1:0] tx_shreg;
   logic [DataBits-1:0] tx_shreg_nxt;
   logic                tx_par;
   logic                tx_par_nxt;
   logic                tx_line_nxt;
   logic                tx_tick;

   assign din_ready = (tx_state == TX_IDLE);
   assign tx_tick   = (tx_timer == TW'(Period - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_timer <= '0;
         tx_pos   <= '0;
         tx_shreg <= '0;
         tx_par   <= 1'b0;
         uart_tx  <= 1'b1;
      end else begin
         tx_state <= tx_state_nxt;
         tx_timer <= tx_timer_nxt;
         tx_pos   <= tx_pos_nxt;
         tx_shreg <= tx_shreg_nxt;
         tx_par   <= tx_par_nxt;
         uart_tx  <= tx_line_nxt;
      end
   end

   // tx_pos is the index of the bit on the line within the whole frame
   always_comb begin
      tx_state_nxt = tx_state;
      tx_timer_nxt = tx_tick ? '0 : tx_timer + 1'b1;
      tx_pos_nxt   = tx_pos;
      tx_shreg_nxt = tx_shreg;
      tx_par_nxt   = tx_par;
      tx_line_nxt  = uart_tx;
      case (tx_state)
         TX_IDLE: begin
            tx_timer_nxt = '0;
            tx_line_nxt  = 1'b1;
            if (din_valid) begin
               tx_state_nxt = TX_START;
               tx_shreg_nxt = din_data;
               tx_par_nxt   = (Parity == ParOdd) ? ~(^din_data) : (^din_data);
               tx_pos_nxt   = '0;
               tx_line_nxt  = 1'b0;
            end
         end
         TX_START: begin
            if (tx_tick) begin
               tx_state_nxt = TX_DATA;
               tx_pos_nxt   = 4'd1;
               tx_line_nxt  = tx_shreg[0];
            end
         end
         TX_DATA: begin
            if (tx_tick) begin
               tx_pos_nxt = tx_pos + 1'b1;
               if (tx_pos == 4'(DataBits)) begin
                  if (Parity != ParNone) begin
                     tx_state_nxt = TX_PARITY;
                     tx_line_nxt  = tx_par;
                  end else begin
                     tx_state_nxt = TX_STOP;
                     tx_line_nxt  = 1'b1;
                  end
               end else begin
                  tx_shreg_nxt = {1'b0, tx_shreg[DataBits-1:1]};
                  tx_line_nxt  = tx_shreg[1];
               end
            end
         end
         TX_PARITY: begin
            if (tx_tick) begin
               tx_state_nxt = TX_STOP;
               tx_pos_nxt   = tx_pos + 1'b1;
               tx_line_nxt  = 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_tick) begin
               if (tx_pos == 4'(FrameBits - 1)) begin
                  tx_state_nxt = TX_IDLE;
               end else begin
                  tx_pos_nxt = tx_pos + 1'b1;
               end
            end
         end
         default: begin
            tx_state_nxt = TX_IDLE;
            tx_line_nxt  = 1'b1;
         end
      endcase
   end

   uart_cfg_rx #(
      .Period   (Period),
      .DataBits (DataBits),
      .Parity   (Parity),
      .StopBits (StopBits)
   ) u_rx (
      .clk             (clk),
      .rst             (rst),
      .uart_rx         (uart_rx),
      .dout_valid      (dout_valid),
      .dout_ready      (dout_ready),
      .dout_data       (dout_data),
      .dout_frame_err  (dout_frame_err),
      .dout_parity_err (dout_parity_err),
      .rx_overrun      (rx_overrun)
   );

endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg: three instances (8N1, 7E2 loopback, 8O1) at
// Period = 10 clocks, each checked against hand-computed line levels and words.
module tb_uart_cfg;

   logic clk = 1'b0;
   logic rst;

   logic       a_din_valid, a_din_ready, a_tx, a_rx;
   logic [7:0] a_din_data, a_dout_data;
   logic       a_dout_valid, a_dout_ready, a_ferr, a_perr, a_ovr;

   logic       b_din_valid, b_din_ready, b_tx;
   logic [6:0] b_din_data, b_dout_data;
   logic       b_dout_valid, b_dout_ready, b_ferr, b_perr, b_ovr;

   logic       c_din_valid, c_din_ready, c_tx, c_rx;
   logic [7:0] c_din_data, c_dout_data;
   logic       c_dout_valid, c_dout_ready, c_ferr, c_perr, c_ovr;

   int n_cmp = 0;
   int n_bad = 0;
   int ovr_cnt = 0;

   always #5 clk = ~clk;

   uart_cfg #(.ClockHz(1000000), .Baud(100000), .DataBits(8), .Parity(0), .StopBits(1)) u_a (
      .clk(clk), .rst(rst), .uart_rx(a_rx), .uart_tx(a_tx),
      .din_valid(a_din_valid), .din_ready(a_din_ready), .din_data(a_din_data),
      .dout_valid(a_dout_valid), .dout_ready(a_dout_ready), .dout_data(a_dout_data),
      .dout_frame_err(a_ferr), .dout_parity_err(a_perr), .rx_overrun(a_ovr));

   uart_cfg #(.ClockHz(1000000), .Baud(100000), .DataBits(7), .Parity(1), .StopBits(2)) u_b (
      .clk(clk), .rst(rst), .uart_rx(b_tx), .uart_tx(b_tx),
      .din_valid(b_din_valid), .din_ready(b_din_ready), .din_data(b_din_data),
      .dout_valid(b_dout_valid), .dout_ready(b_dout_ready), .dout_data(b_dout_data),
      .dout_frame_err(b_ferr), .dout_parity_err(b_perr), .rx_overrun(b_ovr));

   uart_cfg #(.ClockHz(1000000), .Baud(100000), .DataBits(8), .Parity(2), .StopBits(1)) u_c (
      .clk(clk), .rst(rst), .uart_rx(c_rx), .uart_tx(c_tx),
      .din_valid(c_din_valid), .din_ready(c_din_ready), .din_data(c_din_data),
      .dout_valid(c_dout_valid), .dout_ready(c_dout_ready), .dout_data(c_dout_data),
      .dout_frame_err(c_ferr), .dout_parity_err(c_perr), .rx_overrun(c_ovr));

   always @(negedge clk) if (a_ovr) ovr_cnt++;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic get_valid(input int inst);
      if (inst == 0) return a_dout_valid;
      if (inst == 1) return b_dout_valid;
      return c_dout_valid;
   endfunction

   task automatic wait_valid(input int inst, input string tag);
      int k = 0;
      while (!get_valid(inst) && k < 200) begin
         step();
         k++;
      end
      chk(tag, int'(get_valid(inst)), 1);
   endtask

   task automatic pop(input int inst, input string tag);
      if (inst == 0) a_dout_ready = 1'b1;
      else if (inst == 1) b_dout_ready = 1'b1;
      else c_dout_ready = 1'b1;
      step();
      a_dout_ready = 1'b0;
      b_dout_ready = 1'b0;
      c_dout_ready = 1'b0;
      chk(tag, int'(get_valid(inst)), 0);
   endtask

   // bits[0] goes on the line first; each bit is held 10 cycles
   task automatic send_bits(input int inst, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         if (inst == 0) a_rx = bits[i];
         else c_rx = bits[i];
         repeat (10) step();
      end
      if (inst == 0) a_rx = 1'b1;
      else c_rx = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] exp_a;
      int cnt;
      int par_seen;

      rst = 1'b1;
      a_din_valid = 0; a_din_data = '0; a_rx = 1; a_dout_ready = 0;
      b_din_valid = 0; b_din_data = '0; b_dout_ready = 0;
      c_din_valid = 0; c_din_data = '0; c_rx = 1; c_dout_ready = 0;
      repeat (3) step();

      chk("rst_a_tx", int'(a_tx), 1);
      chk("rst_a_rdy", int'(a_din_ready), 1);
      chk("rst_a_vld", int'(a_dout_valid), 0);
      chk("rst_a_ferr", int'(a_ferr), 0);
      chk("rst_a_perr", int'(a_perr), 0);
      chk("rst_a_ovr", int'(a_ovr), 0);
      chk("rst_b_tx", int'(b_tx), 1);
      chk("rst_b_ovr", int'(b_ovr), 0);
      chk("rst_c_tx", int'(c_tx), 1);
      chk("rst_c_rdy", int'(c_din_ready), 1);
      chk("rst_c_ovr", int'(c_ovr), 0);
      rst = 1'b0;
      repeat (5) step();

      // 8N1 transmit of 0xA5: 0,1,0,1,0,0,1,0,1,1
      exp_a = 10'b11_0100_1010;
      a_din_data = 8'hA5;
      a_din_valid = 1'b1;
      step();
      a_din_valid = 1'b0;
      a_din_data = 8'hFF;
      for (int k = 1; k <= 100; k++) begin
         chk($sformatf("a_tx_c%0d", k), int'(a_tx), int'(exp_a[(k-1)/10]));
         if (k == 1 || k == 100) chk($sformatf("a_rdy_c%0d", k), int'(a_din_ready), 0);
         step();
      end
      chk("a_rdy_c101", int'(a_din_ready), 1);
      chk("a_tx_c101", int'(a_tx), 1);
      repeat (10) step();

      // 7E2 loopback of 0x35; parity bit (frame index 8) must be 0
      b_din_data = 7'h35;
      b_din_valid = 1'b1;
      step();
      b_din_valid = 1'b0;
      cnt = 0;
      par_seen = -1;
      while (!b_din_ready && cnt < 300) begin
         if (cnt == 84) par_seen = int'(b_tx);
         cnt++;
         step();
      end
      chk("b_rdy_low", cnt, 110);
      chk("b_par_bit", par_seen, 0);
      wait_valid(1, "b_vld");
      chk("b_data", int'(b_dout_data), 'h35);
      chk("b_ferr", int'(b_ferr), 0);
      chk("b_perr", int'(b_perr), 0);
      pop(1, "b_pop");

      // 8O1 with 0x5A: correct parity bit is 1; first frame sends 0
      send_bits(2, 16'({1'b1, 1'b0, 8'h5A, 1'b0}), 11);
      wait_valid(2, "c_vld_bad");
      chk("c_data_bad", int'(c_dout_data), 'h5A);
      chk("c_perr_bad", int'(c_perr), 1);
      chk("c_ferr_bad", int'(c_ferr), 0);
      pop(2, "c_pop1");
      repeat (10) step();
      send_bits(2, 16'({1'b1, 1'b1, 8'h5A, 1'b0}), 11);
      wait_valid(2, "c_vld_good");
      chk("c_data_good", int'(c_dout_data), 'h5A);
      chk("c_perr_good", int'(c_perr), 0);
      pop(2, "c_pop2");

      // 8N1 framing error on 0x3C, then a clean 0x96 after idle
      send_bits(0, 16'({1'b0, 8'h3C, 1'b0}), 10);
      repeat (20) step();
      wait_valid(0, "a_vld_fe");
      chk("a_data_fe", int'(a_dout_data), 'h3C);
      chk("a_ferr_fe", int'(a_ferr), 1);
      chk("a_perr_fe", int'(a_perr), 0);
      pop(0, "a_pop_fe");
      send_bits(0, 16'({1'b1, 8'h96, 1'b0}), 10);
      wait_valid(0, "a_vld_ok");
      chk("a_data_ok", int'(a_dout_data), 'h96);
      chk("a_ferr_ok", int'(a_ferr), 0);
      pop(0, "a_pop_ok");
      repeat (10) step();

      // overrun: 0x11 held, 0x22 dropped; then 0x22 accepted with ready on completion
      ovr_cnt = 0;
      send_bits(0, 16'({1'b1, 8'h11, 1'b0}), 10);
      repeat (10) step();
      chk("ovr_first", int'(a_dout_data), 'h11);
      send_bits(0, 16'({1'b1, 8'h22, 1'b0}), 10);
      repeat (10) step();
      chk("ovr_held", int'(a_dout_data), 'h11);
      chk("ovr_vld", int'(a_dout_valid), 1);
      chk("ovr_pulses", ovr_cnt, 1);
      fork
         send_bits(0, 16'({1'b1, 8'h22, 1'b0}), 10);
         begin
            repeat (96) step();
            a_dout_ready = 1'b1;
            step();
            a_dout_ready = 1'b0;
         end
      join
      repeat (10) step();
      chk("swap_data", int'(a_dout_data), 'h22);
      chk("swap_vld", int'(a_dout_valid), 1);
      chk("swap_pulses", ovr_cnt, 1);
      pop(0, "a_pop_ovr");

      // 3-cycle glitch must not start a frame
      a_rx = 1'b0;
      repeat (3) step();
      a_rx = 1'b1;
      repeat (150) step();
      chk("glitch_vld", int'(a_dout_valid), 0);

      // reset in the middle of a transmit
      a_din_data = 8'h00;
      a_din_valid = 1'b1;
      step();
      a_din_valid = 1'b0;
      repeat (35) step();
      chk("mid_tx_line", int'(a_tx), 0);
      chk("mid_tx_rdy", int'(a_din_ready), 0);
      rst = 1'b1;
      step();
      chk("rst_tx_line", int'(a_tx), 1);
      chk("rst_tx_rdy", int'(a_din_ready), 1);
      rst = 1'b0;
      repeat (12) step();
      chk("post_rst_line", int'(a_tx), 1);
      chk("post_rst_rdy", int'(a_din_ready), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
